// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: I-cache, D-cache and shared memory port signals of the arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ready;
    logic [DATA_W-1:0] i_rdata;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    // Arbiter view: serves the caches and drives the memory command.
    modport master (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_ready, i_rdata, d_ready, d_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

    // Environment view: caches issue requests, memory answers commands.
    modport slave (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_ready, i_rdata, d_ready, d_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between I-cache and D-cache.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, COOL} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_last_d;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              w_req_i;
    logic              w_req_d;
    logic              w_pick_d;
    logic              w_grant;
    logic              w_leave;

    assign w_req_i  = bus.i_read;
    assign w_req_d  = bus.d_read | bus.d_write;
    // On a tie the side that did not win last time gets the port.
    assign w_pick_d = w_req_d & (~w_req_i | ~r_last_d);

    // Next state plus one-cycle grant/release strobes for the command registers.
    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        w_leave = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req_i | w_req_d) begin
                    w_next  = w_pick_d ? GNT_D : GNT_I;
                    w_grant = 1'b1;
                end
            end
            GNT_I, GNT_D: begin
                if (bus.mem_ready) begin
                    w_next  = COOL;
                    w_leave = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Remember the winner of every grant for tie-breaking (0 = I-cache).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_last_d <= 1'b0;
        else if (w_grant)
            r_last_d <= w_pick_d;
    end

    // Command registers: loaded entering a grant, cleared leaving it; write-back beats read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_grant) begin
            r_mem_read  <= ~w_pick_d | ~bus.d_write;
            r_mem_write <= w_pick_d & bus.d_write;
            r_mem_addr  <= w_pick_d ? bus.d_addr : bus.i_addr;
            r_mem_wdata <= w_pick_d ? bus.d_wdata : '0;
        end else if (w_leave) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end
    end

    assign bus.mem_read  = r_mem_read;
    assign bus.mem_write = r_mem_write;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.i_ready   = (r_state == GNT_I) & bus.mem_ready;
    assign bus.d_ready   = (r_state == GNT_D) & bus.mem_ready;
    assign bus.i_rdata   = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter.
module tb_mem_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;

    typedef struct {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    cmd_t sb[$];
    cmd_t cur;
    int   n_cmp = 0;
    int   n_err = 0;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] w);
        cmd_t c;
        c.rd = rd;
        c.wr = wr;
        c.addr = a;
        c.wdata = w;
        sb.push_back(c);
    endtask

    task automatic chk_cur(input string tag);
        chk({tag, ".rd"}, bus.mem_read, cur.rd);
        chk({tag, ".wr"}, bus.mem_write, cur.wr);
        chk({tag, ".addr"}, bus.mem_addr, cur.addr);
        chk({tag, ".wdata"}, bus.mem_wdata, cur.wdata);
        chk({tag, ".excl"}, bus.mem_read & bus.mem_write, 0);
    endtask

    task automatic check_cmd(input string tag);
        n_cmp++;
        assert (sb.size() != 0) else begin
            n_err++;
            $error("FAIL %s.sb: observed empty scoreboard expected a pending command", tag);
        end
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            chk_cur(tag);
        end
    endtask

    // Entered one cycle after the grant edge; leaves mid-cycle with mem_ready high.
    task automatic serve(input string tag, input bit is_d, input int lat, input logic [DW-1:0] rd);
        check_cmd(tag);
        for (int k = 1; k < lat; k++) begin
            chk({tag, ".busy_i"}, bus.i_ready, 0);
            chk({tag, ".busy_d"}, bus.d_ready, 0);
            step();
            chk_cur({tag, ".hold"});
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rd;
        #1;
        chk({tag, ".i_ready"}, bus.i_ready, !is_d);
        chk({tag, ".d_ready"}, bus.d_ready, is_d);
        chk({tag, ".i_rdata"}, bus.i_rdata, rd);
        chk({tag, ".d_rdata"}, bus.d_rdata, rd);
        chk_cur({tag, ".last"});
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, ".rd"}, bus.mem_read, 0);
        chk({tag, ".wr"}, bus.mem_write, 0);
        chk({tag, ".i_ready"}, bus.i_ready, 0);
        chk({tag, ".d_ready"}, bus.d_ready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected completion");
        $fatal(1);
    end

    initial begin
        bus.i_read = 0;
        bus.i_addr = '0;
        bus.d_read = 0;
        bus.d_write = 0;
        bus.d_addr = '0;
        bus.d_wdata = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 0;
        step();
        step();
        // Reset state, with a stray mem_ready that must not produce a pulse.
        bus.mem_ready = 1;
        #1;
        idle_chk("rst");
        chk("rst.addr", bus.mem_addr, 0);
        chk("rst.wdata", bus.mem_wdata, 0);
        bus.mem_ready = 0;
        rst_n = 1;
        step();

        // Single I read, memory answers in the third command cycle; request held through COOL.
        bus.i_read = 1;
        bus.i_addr = 28'h0000010;
        push(1, 0, 28'h0000010, 0);
        #1;
        chk("t1.lat0", bus.mem_read, 0);
        step();
        serve("t1", 0, 3, {4{32'h1111_2222}});
        step();
        bus.mem_ready = 0;
        #1;
        idle_chk("t1.cool");
        step();
        bus.i_read = 0;
        #1;
        idle_chk("t1.idle");
        step();
        idle_chk("t1.noregrant");
        step();

        // Ties after reset: D, then I, then D again, then I.
        rst_n = 0;
        step();
        rst_n = 1;
        bus.i_read = 1;
        bus.i_addr = 28'h0000A01;
        bus.d_read = 1;
        bus.d_addr = 28'h0000B01;
        push(1, 0, 28'h0000B01, 0);
        push(1, 0, 28'h0000A01, 0);
        step();
        serve("t2.d", 1, 2, {4{32'hD00D_0001}});
        bus.d_read = 0;
        step();
        bus.mem_ready = 0;
        #1;
        idle_chk("t2.cool");
        step();
        idle_chk("t2.idle");
        step();
        serve("t2.i", 0, 1, {4{32'h1CAC_0002}});
        bus.d_read = 1;
        bus.d_addr = 28'h0000B02;
        bus.i_addr = 28'h0000A02;
        push(1, 0, 28'h0000B02, 0);
        push(1, 0, 28'h0000A02, 0);
        step();
        bus.mem_ready = 0;
        step();
        step();
        serve("t2.d2", 1, 2, {4{32'hD00D_0003}});
        bus.d_read = 0;
        step();
        bus.mem_ready = 0;
        step();
        step();
        serve("t2.i2", 0, 1, {4{32'h1CAC_0004}});
        bus.i_read = 0;
        step();
        bus.mem_ready = 0;
        step();

        // Write-back (with d_read also set) then a plain read; mem_ready left high into COOL.
        bus.d_write = 1;
        bus.d_read = 1;
        bus.d_addr = 28'h0123456;
        bus.d_wdata = {16{8'hA5}};
        push(0, 1, 28'h0123456, {16{8'hA5}});
        step();
        serve("t3.wr", 1, 2, {4{32'h0BAD_F00D}});
        bus.d_write = 0;
        bus.d_read = 0;
        bus.d_wdata = '0;
        step();
        #1;
        idle_chk("t3.cool");
        bus.mem_ready = 0;
        step();
        bus.d_read = 1;
        bus.d_addr = 28'h0654321;
        push(1, 0, 28'h0654321, 0);
        step();
        serve("t3.rd", 1, 2, {4{32'hCAFE_0005}});
        bus.d_read = 0;
        step();
        bus.mem_ready = 0;
        step();

        // Spurious mem_ready in IDLE, then a request granted exactly one cycle later.
        bus.mem_ready = 1;
        bus.mem_rdata = {4{32'hDEAD_BEEF}};
        #1;
        idle_chk("t4.spur0");
        step();
        idle_chk("t4.spur1");
        bus.mem_ready = 0;
        bus.i_read = 1;
        bus.i_addr = 28'hFFFFFFF;
        push(1, 0, 28'hFFFFFFF, 0);
        step();
        serve("t4", 0, 1, {4{32'h5555_AAAA}});
        bus.i_read = 0;
        step();
        bus.mem_ready = 0;
        step();

        // Reset during a D write-back grant, then a tie must go to D.
        bus.d_write = 1;
        bus.d_addr = 28'h0000777;
        bus.d_wdata = {4{32'h7777_7777}};
        push(0, 1, 28'h0000777, {4{32'h7777_7777}});
        step();
        check_cmd("t5.grant");
        bus.mem_ready = 1;
        #1;
        rst_n = 0;
        #1;
        idle_chk("t5.async");
        chk("t5.async.addr", bus.mem_addr, 0);
        chk("t5.async.wdata", bus.mem_wdata, 0);
        bus.d_write = 0;
        bus.d_wdata = '0;
        step();
        rst_n = 1;
        #1;
        idle_chk("t5.inflight");
        step();
        idle_chk("t5.ignored");
        bus.mem_ready = 0;
        bus.i_read = 1;
        bus.i_addr = 28'h0000C01;
        bus.d_read = 1;
        bus.d_addr = 28'h0000C02;
        push(1, 0, 28'h0000C02, 0);
        push(1, 0, 28'h0000C01, 0);
        step();
        serve("t5.tie_d", 1, 1, {4{32'h0000_00D5}});
        bus.d_read = 0;
        step();
        bus.mem_ready = 0;
        step();
        step();
        serve("t5.tie_i", 0, 1, {4{32'h0000_0015}});
        bus.i_read = 0;
        step();
        bus.mem_ready = 0;
        step();

        chk("sb.drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
